// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong controller: two clamped paddles, a ball with wall and paddle
// bounces, scoring, serve handling and a game-over hold. All state advances on frame_tick.
module pong_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 50,
  parameter int BALL_SZ     = 8,
  parameter int P1_X        = 40,
  parameter int P2_X        = 600,
  parameter int PADDLE_SPD  = 4,
  parameter int BALL_SPD    = 2,
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p1_srv,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       p2_srv,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] state
);

  localparam logic [1:0] READY = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] POINT = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0] CENTER_X = 10'(SCREEN_W / 2 - BALL_SZ / 2);
  localparam logic [9:0] CENTER_Y = 10'(SCREEN_H / 2 - BALL_SZ / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  // Signed 11-bit geometry so a step below zero shows up as negative.
  localparam logic signed [10:0] S_ZERO    = 11'sd0;
  localparam logic signed [10:0] S_PSPD    = 11'(PADDLE_SPD);
  localparam logic signed [10:0] S_BSPD    = 11'(BALL_SPD);
  localparam logic signed [10:0] S_PMAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic signed [10:0] S_BMAX_Y  = 11'(SCREEN_H - BALL_SZ);
  localparam logic signed [10:0] S_BMAX_X  = 11'(SCREEN_W - BALL_SZ);
  localparam logic signed [10:0] S_BSZ     = 11'(BALL_SZ);
  localparam logic signed [10:0] S_PH      = 11'(PADDLE_H);
  localparam logic signed [10:0] S_P1_FACE = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0] S_P2_X    = 11'(P2_X);
  localparam logic signed [10:0] S_P2_STOP = 11'(P2_X - BALL_SZ);

  logic          server;    // 0: p1 serves, 1: p2 serves
  logic          dx;        // 1: moving right
  logic          dy;        // 1: moving down
  logic [HW-1:0] hold_cnt;

  logic [9:0]    p1_y_n, p2_y_n, ball_x_n, ball_y_n;
  logic [3:0]    score1_n, score2_n;
  logic [1:0]    state_n;
  logic          server_n, dx_n, dy_n;
  logic [HW-1:0] hold_cnt_n;

  logic signed [10:0] bx, by, py1, py2, nx, ny;
  logic               ov1, ov2, hit1, hit2;

  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up,
                                              input logic dn);
    logic signed [10:0] t;
    t = signed'({1'b0, y});
    if (up && !dn)      t = t - S_PSPD;
    else if (dn && !up) t = t + S_PSPD;
    if (t < S_ZERO)      t = S_ZERO;
    else if (t > S_PMAX) t = S_PMAX;
    return t[9:0];
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    p1_y_n     = p1_y;
    p2_y_n     = p2_y;
    ball_x_n   = ball_x;
    ball_y_n   = ball_y;
    score1_n   = score1;
    score2_n   = score2;
    state_n    = state;
    server_n   = server;
    dx_n       = dx;
    dy_n       = dy;
    hold_cnt_n = hold_cnt;

    bx  = signed'({1'b0, ball_x});
    by  = signed'({1'b0, ball_y});
    py1 = signed'({1'b0, p1_y});
    py2 = signed'({1'b0, p2_y});
    nx  = dx ? bx + S_BSPD : bx - S_BSPD;
    ny  = dy ? by + S_BSPD : by - S_BSPD;
    // Overlap is judged on the positions before this frame's moves.
    ov1  = (by + S_BSZ > py1) && (by < py1 + S_PH);
    ov2  = (by + S_BSZ > py2) && (by < py2 + S_PH);
    hit1 = !dx && (bx >= S_P1_FACE) && (nx <= S_P1_FACE) && ov1;
    hit2 = dx && (bx + S_BSZ <= S_P2_X) && (nx + S_BSZ >= S_P2_X) && ov2;

    if (state != OVER) begin
      p1_y_n = paddle_next(p1_y, p1_up, p1_dn);
      p2_y_n = paddle_next(p2_y, p2_up, p2_dn);
    end

    case (state)
      READY: begin
        if (server ? p2_srv : p1_srv) begin
          state_n = PLAY;
          dx_n    = !server;
        end
      end
      PLAY: begin
        if (ny <= S_ZERO) begin
          ball_y_n = 10'd0;
          dy_n     = 1'b1;
        end else if (ny >= S_BMAX_Y) begin
          ball_y_n = S_BMAX_Y[9:0];
          dy_n     = 1'b0;
        end else begin
          ball_y_n = ny[9:0];
        end

        if (hit1) begin
          ball_x_n = S_P1_FACE[9:0];
          dx_n     = 1'b1;
        end else if (hit2) begin
          ball_x_n = S_P2_STOP[9:0];
          dx_n     = 1'b0;
        end else if (nx <= S_ZERO) begin
          ball_x_n   = 10'd0;
          score2_n   = (score2 == WIN) ? score2 : score2 + 4'd1;
          server_n   = 1'b0;
          state_n    = POINT;
          hold_cnt_n = '0;
        end else if (nx >= S_BMAX_X) begin
          ball_x_n   = S_BMAX_X[9:0];
          score1_n   = (score1 == WIN) ? score1 : score1 + 4'd1;
          server_n   = 1'b1;
          state_n    = POINT;
          hold_cnt_n = '0;
        end else begin
          ball_x_n = nx[9:0];
        end
      end
      POINT: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = '0;
          if (score1 == WIN || score2 == WIN) begin
            state_n = OVER;
          end else begin
            state_n  = READY;
            ball_x_n = CENTER_X;
            ball_y_n = CENTER_Y;
          end
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        if (p1_srv || p2_srv) begin
          score1_n = 4'd0;
          score2_n = 4'd0;
          server_n = 1'b0;
          ball_x_n = CENTER_X;
          ball_y_n = CENTER_Y;
          state_n  = READY;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_y     <= PADDLE_Y0;
      p2_y     <= PADDLE_Y0;
      ball_x   <= CENTER_X;
      ball_y   <= CENTER_Y;
      score1   <= 4'd0;
      score2   <= 4'd0;
      state    <= READY;
      server   <= 1'b0;
      dx       <= 1'b1;
      dy       <= 1'b1;
      hold_cnt <= '0;
    end else if (frame_tick) begin
      p1_y     <= p1_y_n;
      p2_y     <= p2_y_n;
      ball_x   <= ball_x_n;
      ball_y   <= ball_y_n;
      score1   <= score1_n;
      score2   <= score2_n;
      state    <= state_n;
      server   <= server_n;
      dx       <= dx_n;
      dy       <= dy_n;
      hold_cnt <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed pins plus long random play compared every
// cycle against an integer game model.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p1_srv = 1'b0;
  logic       p2_up = 1'b0, p2_dn = 1'b0, p2_srv = 1'b0;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .p1_up(p1_up), .p1_dn(p1_dn), .p1_srv(p1_srv),
    .p2_up(p2_up), .p2_dn(p2_dn), .p2_srv(p2_srv),
    .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model (integer arithmetic, named phases) ----------
  typedef enum int {M_READY = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3} phase_t;

  phase_t m_phase = M_READY;
  int m_p1 = 215, m_p2 = 215, m_bx = 316, m_by = 236;
  int m_s1 = 0, m_s2 = 0, m_server = 1, m_hold = 0;
  int m_vx = 2, m_vy = 2;   // signed velocity in pixels per frame
  int games_over = 0, points = 0, bounces = 0;

  function automatic int move_paddle(input int y, input logic up, input logic dn);
    int t = y;
    if (up && !dn) t -= 4;
    if (dn && !up) t += 4;
    if (t < 0)   t = 0;
    if (t > 430) t = 430;
    return t;
  endfunction

  function automatic bit covers(input int by, input int py);
    return (by + 8 > py) && (by < py + 50);
  endfunction

  task automatic model_reset();
    m_phase = M_READY; m_p1 = 215; m_p2 = 215; m_bx = 316; m_by = 236;
    m_s1 = 0; m_s2 = 0; m_server = 1; m_hold = 0; m_vx = 2; m_vy = 2;
  endtask

  task automatic model_tick();
    int old_p1, old_p2, nx, ny;
    old_p1 = m_p1;
    old_p2 = m_p2;
    if (m_phase != M_OVER) begin
      m_p1 = move_paddle(m_p1, p1_up, p1_dn);
      m_p2 = move_paddle(m_p2, p2_up, p2_dn);
    end
    case (m_phase)
      M_READY:
        if ((m_server == 1 && p1_srv) || (m_server == 2 && p2_srv)) begin
          m_phase = M_PLAY;
          m_vx = (m_server == 1) ? 2 : -2;
        end
      M_PLAY: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        if (ny <= 0)        begin ny = 0;   m_vy = 2;  end
        else if (ny >= 472) begin ny = 472; m_vy = -2; end
        if (m_vx < 0 && m_bx >= 48 && nx <= 48 && covers(m_by, old_p1)) begin
          nx = 48; m_vx = 2; bounces++;
        end else if (m_vx > 0 && m_bx + 8 <= 600 && nx + 8 >= 600 && covers(m_by, old_p2)) begin
          nx = 592; m_vx = -2; bounces++;
        end else if (nx <= 0) begin
          nx = 0; if (m_s2 < 9) m_s2++; m_server = 1; m_phase = M_POINT; m_hold = 0; points++;
        end else if (nx >= 632) begin
          nx = 632; if (m_s1 < 9) m_s1++; m_server = 2; m_phase = M_POINT; m_hold = 0; points++;
        end
        m_bx = nx;
        m_by = ny;
      end
      M_POINT: begin
        m_hold++;
        if (m_hold == 60) begin
          m_hold = 0;
          if (m_s1 == 9 || m_s2 == 9) begin
            m_phase = M_OVER; games_over++;
          end else begin
            m_phase = M_READY; m_bx = 316; m_by = 236;
          end
        end
      end
      default:
        if (p1_srv || p2_srv) begin
          m_s1 = 0; m_s2 = 0; m_server = 1; m_bx = 316; m_by = 236; m_phase = M_READY;
        end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          model_reset();
    else if (frame_tick) model_tick();
  end

  always @(negedge clk) begin
    check("cmp p1_y",   int'(p1_y),   m_p1);
    check("cmp p2_y",   int'(p2_y),   m_p2);
    check("cmp ball_x", int'(ball_x), m_bx);
    check("cmp ball_y", int'(ball_y), m_by);
    check("cmp score1", int'(score1), m_s1);
    check("cmp score2", int'(score2), m_s2);
    check("cmp state",  int'(state),  int'(m_phase));
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic buttons_idle();
    p1_up = 0; p1_dn = 0; p1_srv = 0; p2_up = 0; p2_dn = 0; p2_srv = 0;
  endtask

  initial begin
    buttons_idle();
    cyc();
    check("reset p1_y",   int'(p1_y), 215);
    check("reset p2_y",   int'(p2_y), 215);
    check("reset ball_x", int'(ball_x), 316);
    check("reset ball_y", int'(ball_y), 236);
    check("reset state",  int'(state), 0);
    check("reset score",  int'(score1) + int'(score2), 0);
    cyc();
    rst_n = 1;

    // Paddle climbs 4 px per tick from 215 and pins at the top.
    frame_tick = 1; p1_up = 1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (i == 53) check("climb tick53 p1_y", int'(p1_y), 3);
      if (i == 54) check("climb tick54 p1_y", int'(p1_y), 0);
    end
    check("climb end p1_y", int'(p1_y), 0);
    check("climb end p2_y", int'(p2_y), 215);
    p1_up = 0;

    p2_srv = 1; cyc(); p2_srv = 0;
    check("wrong server state", int'(state), 0);
    p1_srv = 1; cyc(); p1_srv = 0;
    check("serve state", int'(state), 1);
    check("serve ball_x held", int'(ball_x), 316);
    cyc();
    check("first move ball_x", int'(ball_x), 318);
    check("first move ball_y", int'(ball_y), 238);

    // No frame ticks: buttons churn but nothing may move.
    frame_tick = 0;
    for (int i = 0; i < 1000; i++) begin
      {p1_up, p1_dn, p1_srv, p2_up, p2_dn, p2_srv} = 6'($urandom);
      cyc();
    end
    check("idle ball_x", int'(ball_x), 318);
    check("idle ball_y", int'(ball_y), 238);
    check("idle p1_y",   int'(p1_y), 0);
    check("idle state",  int'(state), 1);

    for (int i = 0; i < 40000; i++) begin
      frame_tick = ($urandom_range(0, 3) != 0);
      p1_up  = $urandom_range(0, 1) == 1;
      p1_dn  = $urandom_range(0, 1) == 1;
      p2_up  = $urandom_range(0, 1) == 1;
      p2_dn  = $urandom_range(0, 1) == 1;
      p1_srv = $urandom_range(0, 15) == 0;
      p2_srv = $urandom_range(0, 15) == 0;
      if (i == 20000) begin
        rst_n = 0;
        #1;
        check("midrun reset ball_x", int'(ball_x), 316);
        check("midrun reset p2_y",   int'(p2_y), 215);
        check("midrun reset state",  int'(state), 0);
        check("midrun reset score1", int'(score1), 0);
        cyc();
        rst_n = 1;
      end
      cyc();
    end

    $display("random phase: %0d points, %0d paddle bounces, %0d games over",
             points, bounces, games_over);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 SHALL have parameters PADDLE_W 8 and PADDLE_H 50, paddle size in pixels.
REQ-004 SHALL have parameter BALL_SZ, default 8, ball edge in pixels.
REQ-005 SHALL have parameters P1_X 40 and P2_X 600, fixed paddle left-edge x.
REQ-006 SHALL have parameters PADDLE_SPD 4 and BALL_SPD 2, pixels per frame.
REQ-007 SHALL have parameters WIN_SCORE 9 and HOLD_FRAMES 60.
REQ-008 SHALL have ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-009 SHALL have port frame_tick in 1, one-cycle pulse once per frame at vblank start.
REQ-010 SHALL have ports p1_up, p1_dn, p1_srv, p2_up, p2_dn, p2_srv, each in 1, level player buttons.
REQ-011 SHALL have ports p1_y, p2_y out 10, paddle top-edge y.
REQ-012 SHALL have ports ball_x, ball_y out 10, ball top-left corner.
REQ-013 SHALL have ports score1, score2 out 4; state out 2 (0 READY, 1 PLAY, 2 POINT, 3 OVER).

Function
REQ-014 SHALL update all state and outputs only in cycles with frame_tick=1; otherwise hold.
REQ-015 SHALL sample buttons only in frame_tick cycles; no debounce or edge detection.
REQ-016 Paddle: up alone -> y minus PADDLE_SPD; dn alone -> y plus PADDLE_SPD; both or neither -> hold.
REQ-017 Paddle y SHALL clamp to 0..SCREEN_H-PADDLE_H (0..430); no wrap-around.
REQ-018 Paddles SHALL move in every state except OVER.
REQ-019 READY: ball held at center (316,236); serving player = player who lost the last point (p1 after reset/new game).
REQ-020 READY -> PLAY when server's srv=1 on a tick; dx points toward the opponent; dy keeps its current value; other player's srv is ignored.
REQ-021 PLAY: ball moves by BALL_SPD in x and y per tick per direction bits dx, dy.
REQ-022 Wall: new y <= 0 -> y=0, dy=down; new y >= SCREEN_H-BALL_SZ -> clamp to 472, dy=up.
REQ-023 P1 hit: moving left, old x >= P1_X+PADDLE_W, new x <= P1_X+PADDLE_W, vertical overlap -> x=48, dx=right.
REQ-024 P2 hit: moving right, old x+BALL_SZ <= P2_X, new x+BALL_SZ >= P2_X, overlap -> x=592, dx=left.
REQ-025 Overlap: ball_y+BALL_SZ > paddle_y and ball_y < paddle_y+PADDLE_H; uses pre-tick paddle y and pre-tick ball y.
REQ-026 Miss: new x <= 0 (left) or new x >= SCREEN_W-BALL_SZ (right), no hit -> opponent score +1, ball frozen at clamped edge, enter POINT.
REQ-027 Missing player becomes next server.
REQ-028 Arithmetic SHALL use signed 11-bit intermediates so underflow below 0 is detected, not wrapped.
REQ-029 POINT: count HOLD_FRAMES ticks; if either score = WIN_SCORE -> OVER, else -> READY with ball recentered.
REQ-030 OVER: ball and paddles hold; p1_srv or p2_srv on a tick -> scores 0, server p1, ball center, READY.
REQ-031 Score SHALL never exceed WIN_SCORE.

Reset
REQ-032 rst_n=0 SHALL immediately force: p1_y=p2_y=215, ball (316,236), scores 0, state READY, server p1, dx right, dy down, hold counter 0.
REQ-033 Reset mid-PLAY or mid-POINT SHALL discard the rally; first tick after release behaves as READY.

Verification
REQ-034 Reset, p1_up held 60 ticks -> p1_y 215 down to 0 by tick 54, stays 0; p2_y stays 215.
REQ-035 READY, p2_srv=1 tick -> state stays READY; p1_srv=1 tick -> PLAY, next tick ball (318,238).
REQ-036 Ball at (50,200) moving left-down, p1_y=180 -> tick gives x=48, dx right; same with p1_y=300 -> continues to x=0, score2=1, state POINT, server p1.
REQ-037 Ball y=2 moving up -> y=0, dy down; y=470 moving down -> y=472, dy up.
REQ-038 score1=8, p2 misses -> score1=9, POINT for 60 ticks, then OVER; p2_srv tick -> scores 0, READY, ball center.
REQ-039 frame_tick held low 1000 cycles in PLAY with buttons toggling -> no output change.
